// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared tile width, move direction codes and move FSM states
// Revision : 1.0
// ============================================================================
package game_pkg;

    localparam int TILE_W = 12;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_RELEASE = 3'd4
    } move_state_t;

    // Simultaneous presses resolve to the highest-index button.
    function automatic logic [3:0] pick_direction(input logic [3:0] edges);
        if (edges[3])      return DIR_RIGHT;
        else if (edges[2]) return DIR_DOWN;
        else if (edges[1]) return DIR_LEFT;
        else if (edges[0]) return DIR_UP;
        else               return DIR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// btn_edge : 2-flop synchronizer plus rising-edge detector per button bit
// Revision : 1.0
// ============================================================================
module btn_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] rise
);

    logic [N-1:0] meta_q,  meta_d;
    logic [N-1:0] sync_q,  sync_d;
    logic [N-1:0] prev_q,  prev_d;
    logic [N-1:0] armed_q, armed_d;
    logic [1:0]   fill_q,  fill_d;

    // A bit is armed only after a real low sample follows reset, so a button
    // held through reset cannot fake an edge once the pipeline fills.
    always_comb begin
        meta_d  = btn;
        sync_d  = meta_q;
        prev_d  = sync_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (~sync_q & {N{fill_q[1]}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            fill_q  <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = sync_q & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
// move_controller : turns button edges into four-phase summation requests and
//                   commits the returned board with a one-cycle write strobe
// Revision : 1.0
// ============================================================================
module move_controller
    import game_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int W       = TILE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn,
    input  logic [3:0][3:0][W-1:0]   board,
    output logic                     sum_enable,
    output logic [3:0]               sum_direction,
    output logic [3:0][3:0][W-1:0]   sum_matrix,
    input  logic                     sum_ready,
    input  logic [3:0][3:0][W-1:0]   summed_matrix,
    output logic [3:0][3:0][W-1:0]   board_next,
    output logic                     board_we,
    output logic                     moved,
    output logic                     busy,
    output logic                     err,
    output logic [15:0]              move_count
);

    localparam int                  c_tmr_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    logic [3:0] rise;

    btn_edge #(.N(4)) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .rise (rise)
    );

    move_state_t              state_q,         state_d;
    logic                     sum_enable_q,    sum_enable_d;
    logic [3:0]               sum_direction_q, sum_direction_d;
    logic [3:0][3:0][W-1:0]   sum_matrix_q,    sum_matrix_d;
    logic [3:0][3:0][W-1:0]   board_next_q,    board_next_d;
    logic                     board_we_q,      board_we_d;
    logic                     moved_q,         moved_d;
    logic                     busy_q,          busy_d;
    logic                     err_q,           err_d;
    logic [15:0]              move_count_q,    move_count_d;
    logic [c_tmr_w-1:0]       timer_q,         timer_d;

    // Outputs are decided one cycle ahead so every port comes straight off a flop.
    always_comb begin
        state_d         = state_q;
        sum_enable_d    = sum_enable_q;
        sum_direction_d = sum_direction_q;
        sum_matrix_d    = sum_matrix_q;
        board_next_d    = board_next_q;
        board_we_d      = 1'b0;
        moved_d         = 1'b0;
        busy_d          = busy_q;
        err_d           = err_q;
        move_count_d    = move_count_q;
        timer_d         = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    state_d         = ST_ISSUE;
                    sum_matrix_d    = board;
                    sum_direction_d = pick_direction(rise);
                    sum_enable_d    = 1'b1;
                    busy_d          = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
            ST_WAIT: begin
                if (sum_ready) begin
                    state_d      = ST_COMMIT;
                    board_next_d = summed_matrix;
                    board_we_d   = 1'b1;
                    moved_d      = (summed_matrix != sum_matrix_q);
                    if (moved_d) begin
                        move_count_d = move_count_q + 16'd1;
                    end
                end else if (timer_q == c_tmr_last) begin
                    state_d      = ST_RELEASE;
                    sum_enable_d = 1'b0;
                    err_d        = 1'b1;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_COMMIT: begin
                state_d      = ST_RELEASE;
                sum_enable_d = 1'b0;
            end
            ST_RELEASE: begin
                if (!sum_ready) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                sum_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            sum_enable_q    <= 1'b0;
            sum_direction_q <= DIR_NONE;
            sum_matrix_q    <= '0;
            board_next_q    <= '0;
            board_we_q      <= 1'b0;
            moved_q         <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
            move_count_q    <= '0;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            sum_enable_q    <= sum_enable_d;
            sum_direction_q <= sum_direction_d;
            sum_matrix_q    <= sum_matrix_d;
            board_next_q    <= board_next_d;
            board_we_q      <= board_we_d;
            moved_q         <= moved_d;
            busy_q          <= busy_d;
            err_q           <= err_d;
            move_count_q    <= move_count_d;
            timer_q         <= timer_d;
        end
    end

    assign sum_enable    = sum_enable_q;
    assign sum_direction = sum_direction_q;
    assign sum_matrix    = sum_matrix_q;
    assign board_next    = board_next_q;
    assign board_we      = board_we_q;
    assign moved         = moved_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign move_count    = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// ============================================================================
// tb_move_controller : directed + randomized moves against a behavioural
//                      summation responder and a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_move_controller;

    localparam int W       = 12;
    localparam int TIMEOUT = 64;

    typedef logic [3:0][3:0][W-1:0] brd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    brd_t        board;
    logic        sum_enable;
    logic [3:0]  sum_direction;
    brd_t        sum_matrix;
    logic        sum_ready;
    brd_t        summed_matrix;
    brd_t        board_next;
    logic        board_we;
    logic        moved;
    logic        busy;
    logic        err;
    logic [15:0] move_count;

    move_controller #(.TIMEOUT(TIMEOUT), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .board         (board),
        .sum_enable    (sum_enable),
        .sum_direction (sum_direction),
        .sum_matrix    (sum_matrix),
        .sum_ready     (sum_ready),
        .summed_matrix (summed_matrix),
        .board_next    (board_next),
        .board_we      (board_we),
        .moved         (moved),
        .busy          (busy),
        .err           (err),
        .move_count    (move_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Summation responder: ready after rsp_delay enabled cycles, held rsp_hold extra cycles
    int   rsp_delay = 0;
    int   rsp_hold  = 0;
    bit   rsp_never = 0;
    brd_t rsp_result;
    initial begin
        int rcnt = 0;
        int hcnt = 0;
        sum_ready     = 1'b0;
        summed_matrix = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sum_ready = 1'b0;
                rcnt = 0;
                hcnt = 0;
            end else if (sum_enable) begin
                hcnt = 0;
                if (!sum_ready && !rsp_never) begin
                    if (rcnt >= rsp_delay) begin
                        sum_ready     = 1'b1;
                        summed_matrix = rsp_result;
                    end else begin
                        rcnt++;
                    end
                end
            end else begin
                rcnt = 0;
                if (sum_ready) begin
                    if (hcnt >= rsp_hold) sum_ready = 1'b0;
                    else hcnt++;
                end
            end
        end
    end

    // Monitor: captures request, commits and protocol violations
    int         we_cnt = 0, unstable = 0, viol = 0, we_cyc = 0, err_cyc = 0;
    bit         en_seen = 0, cap_moved = 0;
    logic [3:0] cap_dir;
    brd_t       cap_mat, cap_bnext;
    initial begin
        bit prev_en  = 0;
        bit prev_err = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_en  = 0;
                prev_err = 0;
            end else begin
                if (sum_enable && !prev_en) begin
                    cap_dir = sum_direction;
                    cap_mat = sum_matrix;
                    en_seen = 1;
                end else if (sum_enable && (sum_direction != cap_dir || sum_matrix != cap_mat)) begin
                    unstable++;
                end
                if (board_we) begin
                    we_cnt++;
                    cap_moved = moved;
                    cap_bnext = board_next;
                    we_cyc    = cyc;
                end else if (moved) begin
                    viol++;
                end
                if (err && !prev_err) err_cyc = cyc;
                prev_en  = sum_enable;
                prev_err = err;
            end
        end
    end

    // Reference model state
    logic [15:0] m_count = '0;
    bit          m_err   = 0;

    function automatic logic [3:0] top_code(input logic [3:0] b);
        for (int i = 3; i >= 0; i--) if (b[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    function automatic brd_t rand_board();
        brd_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = W'($urandom_range(0, 2048));
        return b;
    endfunction

    task automatic chk_reset_outputs(input string p);
        check({p, "_en"},    256'(sum_enable),    256'(0));
        check({p, "_dir"},   256'(sum_direction), 256'(0));
        check({p, "_smat"},  256'(sum_matrix),    256'(0));
        check({p, "_bnext"}, 256'(board_next),    256'(0));
        check({p, "_we"},    256'(board_we),      256'(0));
        check({p, "_moved"}, 256'(moved),         256'(0));
        check({p, "_busy"},  256'(busy),          256'(0));
        check({p, "_err"},   256'(err),           256'(0));
        check({p, "_cnt"},   256'(move_count),    256'(0));
    endtask

    task automatic do_move(input string tag, input logic [3:0] b, input brd_t brd, input brd_t res,
                           input int dly, input int hold, input bit never, input bit poke);
        int  we0, t0, n;
        bit  exp_moved;
        board      = brd;
        rsp_result = res;
        rsp_delay  = dly;
        rsp_hold   = hold;
        rsp_never  = never;
        we0        = we_cnt;
        unstable   = 0;
        en_seen    = 0;
        t0         = cyc;
        btn        = b;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        check({tag, "_busy_rise"}, 256'(busy), 256'(1));
        if (poke) begin
            tick();
            btn = 4'b0001;
            tick(3);
        end
        btn = 4'b0000;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        check({tag, "_busy_fall"}, 256'(busy), 256'(0));
        tick(3);

        check({tag, "_en_seen"}, 256'(en_seen), 256'(1));
        check({tag, "_dir"},     256'(cap_dir), 256'(top_code(b)));
        check({tag, "_snap"},    256'(cap_mat), 256'(brd));
        check({tag, "_stable"},  256'(unstable), 256'(0));
        check({tag, "_we_cnt"},  256'(we_cnt - we0), 256'(never ? 0 : 1));
        if (never) begin
            m_err = 1;
            check({tag, "_err_lat"}, 256'(err_cyc - t0), 256'(4 + TIMEOUT));
        end else begin
            exp_moved = (res != brd);
            if (exp_moved) m_count = m_count + 16'd1;
            check({tag, "_moved"}, 256'(cap_moved), 256'(exp_moved));
            check({tag, "_bnext"}, 256'(cap_bnext), 256'(res));
            check({tag, "_lat"},   256'(we_cyc - t0), 256'(5 + ((dly > 1) ? dly - 1 : 0)));
        end
        check({tag, "_count"}, 256'(move_count), 256'(m_count));
        check({tag, "_err"},   256'(err), 256'(m_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        brd_t b0, r0, rb, rr;
        int   we0;
        rst        = 1'b0;
        btn        = 4'b0000;
        board      = '0;
        rsp_result = '0;
        tick(4);
        chk_reset_outputs("rst");
        rst = 1'b1;
        tick(4);

        // Canonical right move: rows {2,2,0,0},{4,0,0,0}x3 -> {4,0,0,0}x4
        b0 = '0;
        b0[0][0] = W'(2); b0[0][1] = W'(2);
        for (int r = 1; r < 4; r++) b0[r][0] = W'(4);
        r0 = '0;
        for (int r = 0; r < 4; r++) r0[r][0] = W'(4);
        do_move("right", 4'b1000, b0, r0, 5, 0, 0, 0);

        do_move("echo",   4'b0010, r0, r0, 2, 1, 0, 0);
        rb = rand_board(); rr = rb; rr[1][2] = rr[1][2] ^ W'(3);
        do_move("multi",  4'b0110, rb, rr, 3, 0, 0, 0);
        do_move("tmo",    4'b0001, rb, rb, 0, 0, 1, 0);
        do_move("after",  4'b0100, rb, rr, 1, 0, 0, 0);
        do_move("poke",   4'b1000, rr, rb, 10, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] bb;
            bb = 4'($urandom_range(1, 15));
            rb = rand_board();
            rr = rb;
            if ($urandom_range(0, 1) == 1) begin
                int r, c;
                r = $urandom_range(0, 3);
                c = $urandom_range(0, 3);
                rr[r][c] = rb[r][c] ^ W'($urandom_range(1, 4095));
            end
            do_move($sformatf("rnd%0d", i), bb, rb, rr, $urandom_range(0, 8),
                    $urandom_range(0, 3), 0, 0);
        end

        // Reset asserted mid-WAIT with the button still held
        board      = rand_board();
        rsp_result = '0;
        rsp_delay  = 40;
        rsp_never  = 0;
        btn        = 4'b0100;
        tick(9);
        check("mid_busy", 256'(busy), 256'(1));
        we0 = we_cnt;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("arst");
        m_count = '0;
        m_err   = 0;
        tick(3);
        rst = 1'b1;
        tick(12);
        check("held_busy", 256'(busy), 256'(0));
        check("held_we",   256'(we_cnt - we0), 256'(0));
        btn = 4'b0000;
        tick(4);
        rb = rand_board(); rr = rb; rr[3][3] = rr[3][3] ^ W'(1);
        do_move("post", 4'b0001, rb, rr, 4, 0, 0, 0);

        check("moved_wo_we", 256'(viol), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles waited for sum_ready after sum_enable rises.
REQ-002 SHALL have parameter W, default 12, meaning tile value width.
REQ-003 SHALL have ports, one per line:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  4  raw move buttons, active-high, asynchronous to clk.
- board  input  W x 4 x 4  current game board.
- sum_enable  output  1  request to summation block.
- sum_direction  output  4  one-hot move code to summation block.
- sum_matrix  output  W x 4 x 4  board snapshot presented to summation block.
- sum_ready  input  1  summation result valid.
- summed_matrix  input  W x 4 x 4  summation result.
- board_next  output  W x 4 x 4  committed result.
- board_we  output  1  one-cycle write strobe for board_next.
- moved  output  1  qualifies board_we: result differs from snapshot.
- busy  output  1  move in progress.
- err  output  1  sticky timeout flag.
- move_count  output  16  count of moves that changed the board.

Function
REQ-004 SHALL pass each btn bit through a 2-flop synchronizer, then detect rising edges.
REQ-005 SHALL map btn[3..0] to direction codes 1000 (right), 0100 (down), 0010 (left), 0001 (up).
REQ-006 SHALL, on simultaneous edges, accept only the highest-index bit.
REQ-007 SHALL ignore edges arriving outside IDLE; no queuing.
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, COMMIT, RELEASE.
REQ-009 IDLE -> ISSUE on an accepted edge; same cycle latch board into sum_matrix and the code into sum_direction.
REQ-010 ISSUE: assert sum_enable; -> WAIT next cycle.
REQ-011 WAIT: hold sum_enable, sum_direction and sum_matrix stable; -> COMMIT when sum_ready=1; timeout counter increments each cycle.
REQ-012 WAIT -> RELEASE when the counter reaches TIMEOUT without sum_ready; set err; no board_we.
REQ-013 COMMIT (one cycle): capture summed_matrix into board_next; pulse board_we; moved=1 iff summed_matrix != sum_matrix (any tile); move_count +1 iff moved, wrapping 16'hFFFF -> 0.
REQ-014 RELEASE: drop sum_enable; -> IDLE once sum_ready=0 (four-phase handshake); stay otherwise.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 sum_ready high while in IDLE SHALL be ignored.
REQ-017 err SHALL stay set until reset; operation continues normally after a timeout.
REQ-018 moved SHALL be 0 whenever board_we is 0.
REQ-019 Latency: edge on synchronized btn to board_we SHALL be 3 cycles plus summation latency.

Reset
REQ-020 rst low SHALL immediately force IDLE; sum_enable, board_we, moved, busy, err = 0; sum_direction = 0000; sum_matrix, board_next all zero; move_count = 0; synchronizers and edge detectors cleared.
REQ-021 Reset mid-move SHALL abandon the move with no board_we; the first post-reset edge SHALL be taken only from a 0->1 transition seen after release.

Structure
REQ-022 Direction codes, tile width, and FSM state enum SHALL live in shared package game_pkg, also used by summation.
REQ-023 The synchronizer plus edge detector SHALL be sub-module btn_edge (4 bits wide), instantiated once.

Verification
REQ-024 Bench SHALL include a behavioural summation responder with programmable ready delay, plus these scenarios:
- Board rows {2,2,0,0},{4,0,0,0}x3, btn[3] pulse, responder returns rows {4,0,0,0}x4 after 5 cycles -> sum_direction=1000 during enable, one board_we with moved=1, move_count=1.
- Responder echoes snapshot unchanged -> board_we=1, moved=0, move_count unchanged.
- btn=4'b0110 rising together -> sum_direction=0100 only; one move.
- Responder never raises ready -> err=1 after 64 WAIT cycles, no board_we, busy returns to 0; next move completes normally.
- btn[0] pulse while busy -> ignored, exactly one board_we total.
- rst low during WAIT -> all outputs at reset values immediately; move_count=0; held btn does not retrigger after reset release.
